// File: rtl/hex_entry_ctrl_if.sv
// Keypad-scanner handshake and operand-register write bus for hex_entry_ctrl.
// master: the entry sequencer; slave: scanner plus operand register file.
interface hex_entry_ctrl_if;
    logic [4:0] Din;
    logic       D_ready;
    logic       readn;
    logic       wr_en;
    logic       wr_sel;
    logic [2:0] wr_idx;
    logic [3:0] wr_nib;
    logic       clr;

    modport master (
        input  Din, D_ready,
        output readn, wr_en, wr_sel, wr_idx, wr_nib, clr
    );

    modport slave (
        output Din, D_ready,
        input  readn, wr_en, wr_sel, wr_idx, wr_nib, clr
    );
endinterface

// File: rtl/hex_entry_ctrl.sv
// Hex operand-entry sequencer: keypad handshake, nibble write strobes, cursor/target tracking, blink mask.
// Optional ENTRY_AUTO_ADVANCE_EN: cursor moves one digit right after each hex digit write.
module hex_entry_ctrl #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic                    clk,
    input  logic                    rst,
    hex_entry_ctrl_if.master        bus,
    input  logic [2:0]              BTN,
    output logic                    sel,
    output logic [2:0]              cursor,
    output logic [7:0]              blink
);
    localparam int CNT_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_ACK      = 2'd1,
        ST_WAIT_REL = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic             accept_s;
    logic [2:0]       btn_prev_r, btn_rise_s;
    logic             sel_r, sel_nxt_s;
    logic [2:0]       cursor_r, cursor_nxt_s, cursor_code_s;
    logic             code_move_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic             phase_r, phase_nxt_s;
    logic [7:0]       blink_r, blink_nxt_s;
    logic             readn_r, readn_nxt_s;
    logic             wr_en_r, wr_en_nxt_s;
    logic             clr_r, clr_nxt_s;
    logic             wr_sel_r, wr_sel_nxt_s;
    logic [2:0]       wr_idx_r, wr_idx_nxt_s;
    logic [3:0]       wr_nib_r, wr_nib_nxt_s;

    assign accept_s = (state_r == ST_IDLE) && bus.D_ready;

    // Handshake state register; reset parks in WAIT_REL so a held code is not re-captured
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_WAIT_REL;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Handshake next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.D_ready) state_nxt_s = ST_ACK;
                else             state_nxt_s = ST_IDLE;
            end
            ST_ACK:  state_nxt_s = ST_WAIT_REL;
            ST_WAIT_REL: begin
                if (!bus.D_ready) state_nxt_s = ST_IDLE;
                else              state_nxt_s = ST_WAIT_REL;
            end
            default: state_nxt_s = ST_WAIT_REL;
        endcase
    end

    // Code action decode; strobes are registered so they appear during the ACK cycle
    always_comb begin
        readn_nxt_s   = 1'b1;
        wr_en_nxt_s   = 1'b0;
        clr_nxt_s     = 1'b0;
        wr_sel_nxt_s  = wr_sel_r;
        wr_idx_nxt_s  = wr_idx_r;
        wr_nib_nxt_s  = wr_nib_r;
        code_move_s   = 1'b0;
        cursor_code_s = cursor_r;
        if (accept_s) begin
            readn_nxt_s = 1'b0;
            if (!bus.Din[4]) begin
                wr_en_nxt_s  = 1'b1;
                wr_sel_nxt_s = sel_r;
                wr_idx_nxt_s = cursor_r;
                wr_nib_nxt_s = bus.Din[3:0];
                code_move_s  = 1'b1;
`ifdef ENTRY_AUTO_ADVANCE_EN
                cursor_code_s = cursor_r - 3'd1;
`else
                cursor_code_s = cursor_r;
`endif
            end else if (bus.Din == 5'h10) begin
                clr_nxt_s     = 1'b1;
                wr_sel_nxt_s  = sel_r;
                code_move_s   = 1'b1;
                cursor_code_s = 3'd7;
            end else if (bus.Din == 5'h11) begin
                wr_en_nxt_s   = 1'b1;
                wr_sel_nxt_s  = sel_r;
                wr_idx_nxt_s  = cursor_r + 3'd1;
                wr_nib_nxt_s  = 4'h0;
                code_move_s   = 1'b1;
                cursor_code_s = cursor_r + 3'd1;
            end else begin
                readn_nxt_s = 1'b0;
            end
        end else begin
            readn_nxt_s = 1'b1;
        end
    end

    // Target/cursor update: a code that owns the cursor wins over the move buttons
    always_comb begin
        btn_rise_s = BTN & ~btn_prev_r;
        sel_nxt_s  = sel_r ^ btn_rise_s[0];
        if (code_move_s) begin
            cursor_nxt_s = cursor_code_s;
        end else if (btn_rise_s[1] && !btn_rise_s[2]) begin
            cursor_nxt_s = cursor_r + 3'd1;
        end else if (btn_rise_s[2] && !btn_rise_s[1]) begin
            cursor_nxt_s = cursor_r - 3'd1;
        end else begin
            cursor_nxt_s = cursor_r;
        end
    end

    // Blink timer restarts on any edit-position change so the digit is visible at once
    always_comb begin
        if ((cursor_nxt_s != cursor_r) || (sel_nxt_s != sel_r)) begin
            cnt_nxt_s   = '0;
            phase_nxt_s = 1'b0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s   = '0;
            phase_nxt_s = ~phase_r;
        end else begin
            cnt_nxt_s   = cnt_r + CNT_W'(1);
            phase_nxt_s = phase_r;
        end
        if (phase_nxt_s) blink_nxt_s = 8'h01 << cursor_nxt_s;
        else             blink_nxt_s = 8'h00;
    end

    // Output, cursor, button-history and blink registers
    always_ff @(posedge clk) begin
        if (rst) begin
            readn_r    <= 1'b1;
            wr_en_r    <= 1'b0;
            clr_r      <= 1'b0;
            wr_sel_r   <= 1'b0;
            wr_idx_r   <= 3'd0;
            wr_nib_r   <= 4'h0;
            sel_r      <= 1'b0;
            cursor_r   <= 3'd7;
            btn_prev_r <= 3'b000;
            cnt_r      <= '0;
            phase_r    <= 1'b0;
            blink_r    <= 8'h00;
        end else begin
            readn_r    <= readn_nxt_s;
            wr_en_r    <= wr_en_nxt_s;
            clr_r      <= clr_nxt_s;
            wr_sel_r   <= wr_sel_nxt_s;
            wr_idx_r   <= wr_idx_nxt_s;
            wr_nib_r   <= wr_nib_nxt_s;
            sel_r      <= sel_nxt_s;
            cursor_r   <= cursor_nxt_s;
            btn_prev_r <= BTN;
            cnt_r      <= cnt_nxt_s;
            phase_r    <= phase_nxt_s;
            blink_r    <= blink_nxt_s;
        end
    end

    assign bus.readn  = readn_r;
    assign bus.wr_en  = wr_en_r;
    assign bus.clr    = clr_r;
    assign bus.wr_sel = wr_sel_r;
    assign bus.wr_idx = wr_idx_r;
    assign bus.wr_nib = wr_nib_r;
    assign sel        = sel_r;
    assign cursor     = cursor_r;
    assign blink      = blink_r;
endmodule

// File: tb/tb_hex_entry_ctrl.sv
// Scoreboard bench for hex_entry_ctrl: directed entry scenarios plus randomized keypad/button traffic.
module tb_hex_entry_ctrl;
    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] BTN = 3'b000;
    logic       sel;
    logic [2:0] cursor;
    logic [7:0] blink;

    hex_entry_ctrl_if bus ();

    hex_entry_ctrl #(.BLINK_DIV(DIV)) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus),
        .BTN    (BTN),
        .sel    (sel),
        .cursor (cursor),
        .blink  (blink)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit is_wr;
        bit is_clr;
        int wsel;
        int idx;
        int nib;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;

    // Reference model state: edit target, cursor (0..7), cycles since last position change
    int       m_sel = 0;
    int       m_cur = 7;
    int       m_k = 0;
    bit       m_can = 1'b0;
    bit       m_in_ack = 1'b0;
    bit       m_acc = 1'b0;
    bit [2:0] m_prev = 3'b000;
    int       exp_blink = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic model_edge();
        bit [2:0] rise;
        int old_sel, old_cur, new_cur, code;
        bit moved;
        exp_t e;
        if (rst) begin
            m_sel = 0; m_cur = 7; m_k = 0;
            m_can = 1'b0; m_in_ack = 1'b0; m_acc = 1'b0; m_prev = 3'b000;
        end else begin
            rise    = BTN & ~m_prev;
            m_prev  = BTN;
            old_sel = m_sel;
            old_cur = m_cur;
            new_cur = old_cur;
            moved   = 1'b0;
            m_acc   = bus.D_ready && m_can;
            if (m_acc) begin
                m_can = 1'b0; m_in_ack = 1'b1;
            end else if (m_in_ack) begin
                m_in_ack = 1'b0;
            end else if (!m_can && !bus.D_ready) begin
                m_can = 1'b1;
            end
            if (m_acc) begin
                e = '{is_wr: 1'b0, is_clr: 1'b0, wsel: old_sel, idx: 0, nib: 0};
                code = int'(bus.Din);
                if (code < 16) begin
                    e.is_wr = 1'b1; e.idx = old_cur; e.nib = code; moved = 1'b1;
`ifdef ENTRY_AUTO_ADVANCE_EN
                    new_cur = (old_cur + 7) % 8;
`endif
                end else if (code == 16) begin
                    e.is_clr = 1'b1; new_cur = 7; moved = 1'b1;
                end else if (code == 17) begin
                    new_cur = (old_cur + 1) % 8;
                    e.is_wr = 1'b1; e.idx = new_cur; e.nib = 0; moved = 1'b1;
                end
                exp_q.push_back(e);
            end
            if (!moved) begin
                if (rise[1] && !rise[2])      new_cur = (old_cur + 1) % 8;
                else if (rise[2] && !rise[1]) new_cur = (old_cur + 7) % 8;
            end
            m_sel = old_sel ^ int'(rise[0]);
            m_cur = new_cur;
            if (m_cur != old_cur || m_sel != old_sel) m_k = 0;
            else                                      m_k++;
        end
        exp_blink = (((m_k / DIV) % 2) == 1) ? (1 << m_cur) : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        model_edge();
    endtask

    task automatic press(input logic [2:0] b);
        BTN = b;
        tick();
        BTN = 3'b000;
        tick();
    endtask

    task automatic send_code(input logic [4:0] code, input logic [2:0] b);
        int n = 0;
        bus.Din = code;
        bus.D_ready = 1'b1;
        BTN = b;
        tick();
        while (!m_acc && n < 8) begin
            tick();
            n++;
        end
        if (!m_acc) chk("accept_timeout", 0, 1);
        BTN = 3'b000;
        repeat ($urandom_range(0, 2)) tick();
        bus.D_ready = 1'b0;
        tick();
        tick();
    endtask

    // Monitor: every cycle either pops one expected strobe set or requires an idle bus
    always @(negedge clk) begin
        if (run) begin
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                chk("readn", int'(bus.readn), 0);
                chk("wr_en", int'(bus.wr_en), int'(mon_e.is_wr));
                chk("clr", int'(bus.clr), int'(mon_e.is_clr));
                if (mon_e.is_wr || mon_e.is_clr) chk("wr_sel", int'(bus.wr_sel), mon_e.wsel);
                if (mon_e.is_wr) begin
                    chk("wr_idx", int'(bus.wr_idx), mon_e.idx);
                    chk("wr_nib", int'(bus.wr_nib), mon_e.nib);
                end
            end else begin
                chk("readn_idle", int'(bus.readn), 1);
                chk("wr_en_idle", int'(bus.wr_en), 0);
                chk("clr_idle", int'(bus.clr), 0);
            end
            chk("sel", int'(sel), m_sel);
            chk("cursor", int'(cursor), m_cur);
            chk("blink", int'(blink), exp_blink);
        end
    end

    initial begin
        int r;
        int n;
        bus.Din = 5'h0A;
        bus.D_ready = 1'b1;
        rst = 1'b1;
        tick();
        run = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_wr_idx", int'(bus.wr_idx), 0);
        chk("rst_wr_nib", int'(bus.wr_nib), 0);
        chk("rst_wr_sel", int'(bus.wr_sel), 0);
        rst = 1'b0;
        tick();
        tick();
        bus.D_ready = 1'b0;
        tick();
        send_code(5'h0A, 3'b000);

        for (int i = 1; i <= 8; i++) send_code(5'(i), 3'b000);

        BTN = 3'b001;
        tick();
        tick();
        send_code(5'h03, 3'b001);
        BTN = 3'b001;
        repeat (3) tick();
        BTN = 3'b000;
        tick();

        n = 0;
        while (m_cur != 0 && n < 8) begin
            press(3'b010);
            n++;
        end
        press(3'b100);
        press(3'b010);
        repeat (2 * DIV + 2) tick();

        repeat (3) press(3'b010);
        send_code(5'h11, 3'b000);
        send_code(5'h10, 3'b000);
        send_code(5'h1F, 3'b000);
        send_code(5'h07, 3'b100);
        press(3'b110);

        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 3) == 0) bus.D_ready = ~bus.D_ready;
            if ($urandom_range(0, 2) == 0) begin
                r = $urandom_range(0, 9);
                if (r < 6)       bus.Din = 5'($urandom_range(0, 15));
                else if (r == 6) bus.Din = 5'h10;
                else if (r == 7) bus.Din = 5'h11;
                else if (r == 8) bus.Din = 5'h1F;
                else             bus.Din = 5'($urandom_range(16, 31));
            end
            if ($urandom_range(0, 2) == 0) BTN = 3'($urandom_range(0, 7));
            tick();
        end

        rst = 1'b0;
        bus.D_ready = 1'b0;
        BTN = 3'b000;
        repeat (4) tick();
        @(negedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hex_entry_ctrl.md
# hex_entry_ctrl

Sequencer for the hex operand-entry datapath: accepts digit/command codes from the keypad scanner through a ready/ack handshake, tracks which 32-bit operand (A or B) and which nibble is being edited, and issues single-cycle nibble write strobes to the operand registers. It also generates the cursor blink mask for the 8-digit seven-segment display. It sits between the keypad scanner/button debouncers and the operand register file feeding the ALU/display.

## Interface
Parameters:
- BLINK_DIV, 25_000_000, cycles per blink half-period (≥2)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- Din  in  5  keypad code; Din[4]=0: hex digit Din[3:0]; Din[4]=1: command (5'h10 clear operand, 5'h11 backspace, others ignored)
- D_ready  in  1  scanner has a valid code on Din (level, held until ack seen)
- BTN  in  3  debounced buttons, rising edge acts: [0] toggle target A/B, [1] cursor left, [2] cursor right
- readn  out  1  active-low ack to scanner, one-cycle low pulse per accepted code
- wr_en  out  1  one-cycle nibble write strobe
- wr_sel  out  1  target operand of write/clear: 0=A, 1=B
- wr_idx  out  3  nibble index written (7 = most significant, leftmost digit)
- wr_nib  out  4  nibble value
- clr  out  1  one-cycle strobe: zero whole operand wr_sel
- sel  out  1  current target operand
- cursor  out  3  current nibble index
- blink  out  8  per-digit blank mask for display

## Operation
- Handshake FSM states: IDLE, ACK, WAIT_REL.
  - IDLE: D_ready=1 → capture Din, go ACK.
  - ACK (one cycle): readn=0; act on captured code; go WAIT_REL.
  - WAIT_REL: stay until D_ready=0 sampled, then IDLE. No code accepted while D_ready stays high.
- Code actions in ACK:
  - Hex digit: wr_en=1, wr_sel=sel, wr_idx=cursor, wr_nib=Din[3:0]; cursor advance per Configuration.
  - 5'h10: clr=1, wr_sel=sel, cursor←7.
  - 5'h11 (backspace): cursor←cursor+1 (wrap 7→0), then wr_en=1 writing 0 at new cursor in the same cycle.
  - Other command codes: readn pulse only, no write.
- Buttons: rising-edge detect per bit (registered previous value, reset 0). BTN[0] toggles sel; BTN[1] cursor+1 (7→0 wrap); BTN[2] cursor−1 (0→7 wrap). Buttons act in any FSM state.
- Simultaneous events, same cycle: code action uses pre-update sel and cursor; any code-driven cursor change overrides BTN[1]/BTN[2]; BTN[0] toggle still applies. BTN[1] and BTN[2] together: no move.
- Blink: counter 0..BLINK_DIV−1; phase toggles on wrap. blink = phase ? (8'b1 << cursor) : 8'h00. Any change of cursor or sel resets counter to 0 and phase to 0 (digit shown immediately).

## Timing
- Reset values: readn=1, wr_en=0, clr=0, wr_sel=0, wr_idx=0, wr_nib=0, sel=0, cursor=7, blink=0, counter=0, phase=0, FSM=WAIT_REL (a D_ready held across reset is not re-captured).
- D_ready first sampled high in IDLE at edge N → readn=0 and wr_en/clr asserted during cycle N+1 (all registered); deasserted at N+2.
- Minimum 3 cycles per code (IDLE→ACK→WAIT_REL→IDLE with D_ready low one cycle).
- Button edge at edge N → sel/cursor updated in cycle N+1.
- Reset mid-handshake: all strobes drop next cycle, FSM to WAIT_REL.

## Configuration
- ENTRY_AUTO_ADVANCE_EN defined: after a hex digit write, cursor←cursor−1 (wrap 0→7), calculator-style left-to-right entry.
- Undefined: cursor unchanged after a digit write; movement only by buttons/backspace/clear.

## Test plan
- Reset with D_ready=1 held, release rst, drop D_ready, then present 5'h0A → exactly one readn pulse, wr_en with wr_sel=0, wr_idx=7, wr_nib=4'hA; no capture of the held code.
- With auto-advance, enter 1,2,…,8 → wr_idx 7..0 in order, cursor wraps to 7 after eighth digit; without macro all writes at idx 7.
- BTN[0] rising edge then digit 5'h03 → wr_sel=1, sel=1; holding BTN[0] high produces no further toggles.
- Cursor=0, press BTN[2] → cursor=7; press BTN[1] → cursor=0; blink=8'h01 after BLINK_DIV cycles (BLINK_DIV=4 in bench), 0 in the following 4.
- Backspace 5'h11 at cursor=3 → cursor=4, wr_en with wr_idx=4, wr_nib=0; 5'h10 → clr=1, cursor=7; 5'h1F → readn pulse only.
- Digit capture in ACK with BTN[2] edge same cycle → write at old cursor, cursor follows code rule only.
